// File: rtl/posit_normalise.sv
// posit_normalise: two-stage normaliser ahead of posit_rounding (leading-one alignment, regime/exponent split).
// Define POSIT_NORM_SKID_EN for a registered in_ready_o backed by a one-entry skid buffer.

typedef enum logic [1:0] {
  POSIT32_ES2 = 2'd0,
  POSIT16_ES1 = 2'd1,
  POSIT8_ES2  = 2'd2,
  POSIT64_ES3 = 2'd3
} posit_format_e;

function automatic int unsigned posit_width(input posit_format_e f);
  case (f)
    POSIT16_ES1: return 16;
    POSIT8_ES2:  return 8;
    POSIT64_ES3: return 64;
    default:     return 32;
  endcase
endfunction

function automatic int unsigned exp_bits(input posit_format_e f);
  case (f)
    POSIT16_ES1: return 1;
    POSIT64_ES3: return 3;
    default:     return 2;
  endcase
endfunction

module posit_normalise #(
  parameter  posit_format_e pFormat = posit_format_e'(0),
  localparam int unsigned   N       = posit_width(pFormat),
  localparam int unsigned   ES      = exp_bits(pFormat),
  localparam int unsigned   RS      = $clog2(N),
  localparam int unsigned   SW      = RS + ES + 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 sign_i,
  input  logic signed [SW-1:0] scale_i,
  input  logic [2*N-1:0]       mant_i,
  input  logic                 nar_i,
  input  logic                 zero_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ES-1:0]        E_O,
  output logic [2*N-1:0]       Comp_Mant_N,
  output logic signed [RS+4:0] R_O,
  output logic                 sign_Exponent_O,
  output logic                 Sign,
  output logic                 NaR,
  output logic                 zero
);

  localparam int unsigned MW = 2 * N;
  localparam int unsigned LW = $clog2(MW);
  localparam int unsigned TW = SW + 1;

  logic                 r_v1, r_v2;
  logic                 w_s1_load, w_s2_load;
  logic                 w_src_valid, w_src_sign, w_src_nar, w_src_zero;
  logic signed [SW-1:0] w_src_scale;
  logic [MW-1:0]        w_src_mant;

  assign w_s2_load   = ~r_v2 | out_ready_i;
  assign w_s1_load   = ~r_v1 | w_s2_load;
  assign out_valid_o = r_v2;

`ifdef POSIT_NORM_SKID_EN
  logic                 r_sk_v, r_sk_sign, r_sk_nar, r_sk_zero;
  logic signed [SW-1:0] r_sk_scale;
  logic [MW-1:0]        r_sk_mant;

  // The skid entry is older than anything on the input port, so it always feeds S1 first.
  assign in_ready_o  = ~r_sk_v;
  assign w_src_valid = r_sk_v | in_valid_i;
  assign w_src_sign  = r_sk_v ? r_sk_sign  : sign_i;
  assign w_src_nar   = r_sk_v ? r_sk_nar   : nar_i;
  assign w_src_zero  = r_sk_v ? r_sk_zero  : zero_i;
  assign w_src_scale = r_sk_v ? r_sk_scale : scale_i;
  assign w_src_mant  = r_sk_v ? r_sk_mant  : mant_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_sk_v <= 1'b0;
    end else if (r_sk_v) begin
      if (w_s1_load) r_sk_v <= 1'b0;
    end else if (in_valid_i && !w_s1_load) begin
      r_sk_v <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!r_sk_v && in_valid_i && !w_s1_load) begin
      r_sk_sign  <= sign_i;
      r_sk_nar   <= nar_i;
      r_sk_zero  <= zero_i;
      r_sk_scale <= scale_i;
      r_sk_mant  <= mant_i;
    end
  end
`else
  assign in_ready_o  = w_s1_load;
  assign w_src_valid = in_valid_i;
  assign w_src_sign  = sign_i;
  assign w_src_nar   = nar_i;
  assign w_src_zero  = zero_i;
  assign w_src_scale = scale_i;
  assign w_src_mant  = mant_i;
`endif

  logic [LW-1:0] w_lead, w_shamt;
  logic          w_s1_zero;
  logic [MW-1:0] w_s1_mant;
  logic [TW-1:0] w_s1_t;

  always_comb begin
    w_lead = '0;
    for (int unsigned i = 0; i < MW; i++) begin
      if (w_src_mant[i]) w_lead = LW'(i);
    end
    w_shamt   = LW'(MW - 1) - w_lead;
    w_s1_zero = ~w_src_nar & (w_src_zero | ~|w_src_mant);
    w_s1_mant = '0;
    w_s1_t    = '0;
    if (!(w_src_nar || w_s1_zero)) begin
      w_s1_mant = w_src_mant << w_shamt;
      w_s1_t    = {w_src_scale[SW-1], w_src_scale} + TW'(w_lead) - TW'(MW - 2);
    end
  end

  logic                 r1_sign, r1_nar, r1_zero;
  logic [MW-1:0]        r1_mant;
  logic signed [TW-1:0] r1_t;

  logic signed [TW-1:0] w_k;
  logic [TW-1:0]        w_mag;
  logic                 w_force;
  logic [ES-1:0]        w_e;
  logic [RS+4:0]        w_r;
  logic                 w_se;
  logic [MW-1:0]        w_m;

  // Bubbles and special values present an all-zero bundle so downstream never sees stale fields.
  always_comb begin
    w_k     = r1_t >>> ES;
    w_mag   = (w_k < 0) ? TW'(-w_k) : TW'(w_k + 1);
    if (w_mag > TW'(N)) w_mag = TW'(N);
    w_force = ~r_v1 | r1_nar | r1_zero;
    w_e     = w_force ? '0 : r1_t[ES-1:0];
    w_r     = w_force ? '0 : w_mag[RS+4:0];
    w_se    = ~w_force & (w_k < 0);
    w_m     = w_force ? '0 : r1_mant;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_v1            <= 1'b0;
      r_v2            <= 1'b0;
      r1_sign         <= 1'b0;
      r1_nar          <= 1'b0;
      r1_zero         <= 1'b0;
      r1_mant         <= '0;
      r1_t            <= '0;
      E_O             <= '0;
      Comp_Mant_N     <= '0;
      R_O             <= '0;
      sign_Exponent_O <= 1'b0;
      Sign            <= 1'b0;
      NaR             <= 1'b0;
      zero            <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_v2            <= r_v1;
        E_O             <= w_e;
        Comp_Mant_N     <= w_m;
        R_O             <= w_r;
        sign_Exponent_O <= w_se;
        Sign            <= r_v1 & r1_sign;
        NaR             <= r_v1 & r1_nar;
        zero            <= r_v1 & r1_zero;
      end
      if (w_s1_load) begin
        r_v1    <= w_src_valid;
        r1_sign <= w_src_sign;
        r1_nar  <= w_src_nar;
        r1_zero <= w_s1_zero;
        r1_mant <= w_s1_mant;
        r1_t    <= w_s1_t;
      end
    end
  end

endmodule

// File: tb/tb_posit_normalise.sv
// Directed self-checking bench for posit_normalise at the default format (N=32, ES=2).
module tb_posit_normalise;
  localparam int SW = 11;
  localparam int MW = 64;
  localparam int RW = 10;
`ifdef POSIT_NORM_SKID_EN
  localparam int EXP_HOLD = 3;
`else
  localparam int EXP_HOLD = 2;
`endif
  localparam logic [63:0] B63 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] B62 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] B60 = 64'h1000_0000_0000_0000;

  logic                 clk = 1'b0;
  logic                 rst, flush, in_valid, in_ready, sign, nar_in, zero_in;
  logic                 out_valid, out_ready, sexp, sign_o, nar_o, zero_o;
  logic signed [SW-1:0] scale;
  logic [MW-1:0]        mant, mant_o;
  logic [1:0]           e_o;
  logic signed [RW-1:0] r_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  posit_normalise dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .sign_i(sign), .scale_i(scale), .mant_i(mant), .nar_i(nar_in), .zero_i(zero_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .E_O(e_o), .Comp_Mant_N(mant_o), .R_O(r_o), .sign_Exponent_O(sexp),
    .Sign(sign_o), .NaR(nar_o), .zero(zero_o)
  );

  typedef struct {
    logic        sg;
    int          sc;
    logic [63:0] m;
    logic        na, ze;
    int          e;
    logic [63:0] em;
    int          r;
    logic        se, esg, ena, eze;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic sg, input int sc, input logic [63:0] m, input logic na,
                              input logic ze, input int e, input logic [63:0] em, input int r,
                              input logic se, input logic esg, input logic ena, input logic eze);
    vec_t v;
    v.sg = sg; v.sc = sc; v.m = m; v.na = na; v.ze = ze;
    v.e = e; v.em = em; v.r = r; v.se = se; v.esg = esg; v.ena = ena; v.eze = eze;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " out_valid"}, 64'(out_valid), 64'd0);
    check({tag, " E_O"}, 64'(e_o), 64'd0);
    check({tag, " Comp_Mant_N"}, mant_o, 64'd0);
    check({tag, " R_O"}, 64'(r_o), 64'd0);
    check({tag, " flags"}, 64'({sexp, sign_o, nar_o, zero_o}), 64'd0);
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Fill both stages, then kill with reset or flush while a new bundle is offered.
  task automatic kill_test(input bit use_rst);
    int seen;
    string tag;
    tag = use_rst ? "rst" : "flush";
    out_ready = 1'b0; sign = 1'b1; mant = B62; nar_in = 1'b0; zero_in = 1'b0;
    scale = SW'(4); in_valid = 1'b1; tick();
    scale = SW'(8); tick();
    check({tag, " pre out_valid"}, 64'(out_valid), 64'd1);
    scale = SW'(12);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check_cleared(tag);
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      tick();
      if (out_valid) seen++;
    end
    check({tag, " later emits"}, 64'(seen), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs.push_back(mk(0,    0, B62, 0, 0, 0, B63,  1, 0, 0, 0, 0));
    vecs.push_back(mk(0,    0, B63, 0, 0, 1, B63,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1,    0, B60, 0, 0, 2, B63,  1, 1, 1, 0, 0));
    vecs.push_back(mk(0,  200, B62, 0, 0, 0, B63, 32, 0, 0, 0, 0));
    vecs.push_back(mk(1, -200, B62, 0, 0, 0, B63, 32, 1, 1, 0, 0));
    vecs.push_back(mk(0,  123, B62, 0, 0, 3, B63, 31, 0, 0, 0, 0));
    vecs.push_back(mk(0,  127, B62, 0, 0, 3, B63, 32, 0, 0, 0, 0));
    vecs.push_back(mk(0, -124, B62, 0, 0, 0, B63, 31, 1, 0, 0, 0));
    vecs.push_back(mk(0, -125, B62, 0, 0, 3, B63, 32, 1, 0, 0, 0));
    vecs.push_back(mk(0,   -1, B62, 0, 0, 3, B63,  1, 1, 0, 0, 0));
    vecs.push_back(mk(0,   -5, B62, 0, 0, 3, B63,  2, 1, 0, 0, 0));
    vecs.push_back(mk(0,    0, 64'd5, 0, 0, 0, 64'hA000_0000_0000_0000, 15, 1, 0, 0, 0));
    vecs.push_back(mk(0,   10, 64'd3, 0, 0, 1, 64'hC000_0000_0000_0000, 13, 1, 0, 0, 0));
    vecs.push_back(mk(0,   -1, '1,    0, 0, 0, '1,  1, 0, 0, 0, 0));
    vecs.push_back(mk(1,    5, B62,   0, 1, 0, 64'd0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(0,    7, 64'd0, 0, 0, 0, 64'd0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0,    3, 64'd123, 1, 0, 0, 64'd0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1,    3, 64'd0, 1, 1, 0, 64'd0, 0, 0, 1, 1, 0));

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sign = 1'b0; scale = '0; mant = '0; nar_in = 1'b0; zero_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_cleared("reset");

    foreach (vecs[i]) begin
      sign = vecs[i].sg; scale = SW'(vecs[i].sc); mant = vecs[i].m;
      nar_in = vecs[i].na; zero_in = vecs[i].ze; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d latency1 out_valid", i), 64'(out_valid), 64'd0);
      tick();
      check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("v%0d E_O", i), 64'(e_o), 64'(vecs[i].e));
      check($sformatf("v%0d Comp_Mant_N", i), mant_o, vecs[i].em);
      check($sformatf("v%0d R_O", i), 64'(r_o), 64'(vecs[i].r));
      check($sformatf("v%0d sign_Exponent_O", i), 64'(sexp), 64'(vecs[i].se));
      check($sformatf("v%0d Sign", i), 64'(sign_o), 64'(vecs[i].esg));
      check($sformatf("v%0d NaR", i), 64'(nar_o), 64'(vecs[i].ena));
      check($sformatf("v%0d zero", i), 64'(zero_o), 64'(vecs[i].eze));
    end
    tick(); tick();

    // Stream five bundles with a downstream stall on loop cycles 3..6.
    begin
      int acc, emit, drop_occ;
      logic stalled;
      logic [RW-1:0] held_r;
      acc = 0; emit = 0; drop_occ = -1; stalled = 1'b0; held_r = '0;
      nar_in = 1'b0; zero_in = 1'b0; mant = B62;
      for (int c = 0; c < 40 && emit < 5; c++) begin
        out_ready = !(c >= 3 && c <= 6);
        in_valid  = (acc < 5);
        scale     = SW'(acc * 4);
        sign      = acc[0];
        @(negedge clk);
        if (stalled) begin
          check($sformatf("stream hold valid c%0d", c), 64'(out_valid), 64'd1);
          check($sformatf("stream hold R_O c%0d", c), 64'(r_o), 64'(held_r));
        end
        if (!in_ready && drop_occ < 0) drop_occ = acc - emit;
        if (out_valid && out_ready) begin
          check($sformatf("stream out%0d R_O", emit), 64'(r_o), 64'(emit + 1));
          check($sformatf("stream out%0d Sign", emit), 64'(sign_o), 64'(emit % 2));
          emit++;
        end
        stalled = out_valid && !out_ready;
        held_r  = r_o;
        if (in_valid && in_ready) acc++;
        tick();
      end
      in_valid = 1'b0;
      check("stream emitted count", 64'(emit), 64'd5);
      check("stream occupancy at in_ready drop", 64'(drop_occ), 64'(EXP_HOLD));
    end
    tick();

    kill_test(1'b0);
    kill_test(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
